result_reporter_tx: RTL and testbench

RESULT_REPORTER_TX -- requirements
Module: result_reporter_tx

---
 rtl/result_report_pkg.sv | 28 ++
 rtl/result_reporter_tx_if.sv | 20 ++
 rtl/rpt_check_accum.sv | 44 ++++
 rtl/result_reporter_tx.sv | 143 ++++++++++++++
 tb/tb_result_reporter_tx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_report_pkg.sv
// Shared constants, state type and CRC helper for the result reporter frame transmitter.
package result_report_pkg;

    localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
    localparam logic [7:0]  LEN_BYTE         = 8'h0C;
    localparam int unsigned FRAME_BYTES      = 16;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [3:0]  LAST_HDR_IDX     = 4'd2;
    localparam logic [3:0]  LAST_PAYLOAD_IDX = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CHK
    } rpt_state_e;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/result_reporter_tx_if.sv
// Byte stream toward the PC: valid/data from the reporter, ready back from the PC.
interface result_reporter_tx_if;

    logic       pc_rsp_valid;
    logic [7:0] pc_rsp_data;
    logic       pc_rsp_ready;

    modport master (
        output pc_rsp_valid,
        output pc_rsp_data,
        input  pc_rsp_ready
    );

    modport slave (
        input  pc_rsp_valid,
        input  pc_rsp_data,
        output pc_rsp_ready
    );

endinterface

// File: rtl/rpt_check_accum.sv
// Running check over frame bytes B1..B14: additive two's-complement sum by default,
// CRC-8 when RESULT_REPORTER_CRC8_EN is defined.
module rpt_check_accum
    import result_report_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       update,
    input  logic [7:0] data_in,
    output logic [7:0] result
);

    logic [7:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = 8'h00;
        end else if (update) begin
`ifdef RESULT_REPORTER_CRC8_EN
            acc_d = crc8_update(acc_q, data_in);
`else
            acc_d = acc_q + data_in;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef RESULT_REPORTER_CRC8_EN
    assign result = acc_q;
`else
    // Negated sum makes B1..B15 add to zero modulo 256.
    assign result = 8'h00 - acc_q;
`endif

endmodule

// File: rtl/result_reporter_tx.sv
// Sends a 16-byte result frame (sync, seq, length, 12-byte snapshot, check) on request.
// Build option RESULT_REPORTER_CRC8_EN selects CRC-8 instead of the additive check byte.
module result_reporter_tx
    import result_report_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rpt_req,
    input  logic [15:0]          error_count,
    input  logic [15:0]          min_latency,
    input  logic [15:0]          max_latency,
    input  logic [15:0]          average_latency,
    input  logic [31:0]          throughput,
    result_reporter_tx_if.master pc_rsp,
    output logic                 rpt_busy,
    output logic                 rpt_done,
    output logic                 rpt_timeout,
    output logic                 rpt_drop
);

    localparam logic [3:0]  CHK_IDX     = 4'(FRAME_BYTES - 1);
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);

    rpt_state_e  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] stall_q, stall_d;
    logic [95:0] snap_q;
    logic        drop_q;

    logic        capture;
    logic        accept;
    logic        chk_update;
    logic [3:0]  payload_sel;
    logic [95:0] snap_shift;
    logic [7:0]  tx_byte;
    logic [7:0]  chk_byte;

    assign pc_rsp.pc_rsp_valid = (state_q != IDLE);
    assign pc_rsp.pc_rsp_data  = tx_byte;
    assign accept              = pc_rsp.pc_rsp_valid & pc_rsp.pc_rsp_ready;
    assign rpt_busy            = (state_q != IDLE);
    assign rpt_drop            = drop_q;

    // Snapshot is stored MSB-first, so B3 is the top byte and B14 the bottom one.
    assign payload_sel = LAST_PAYLOAD_IDX - idx_q;
    assign snap_shift  = snap_q >> {payload_sel, 3'b000};

    always_comb begin
        tx_byte = 8'h00;
        if (state_q != IDLE) begin
            if (idx_q == 4'd0) begin
                tx_byte = SYNC_BYTE;
            end else if (idx_q == 4'd1) begin
                tx_byte = seq_q;
            end else if (idx_q == LAST_HDR_IDX) begin
                tx_byte = LEN_BYTE;
            end else if (idx_q == CHK_IDX) begin
                tx_byte = chk_byte;
            end else begin
                tx_byte = snap_shift[7:0];
            end
        end
    end

    assign chk_update = accept && (idx_q != 4'd0) && (idx_q != CHK_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        stall_d     = stall_q;
        capture     = 1'b0;
        rpt_done    = 1'b0;
        rpt_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rpt_req) begin
                    capture = 1'b1;
                    state_d = HDR;
                    idx_d   = 4'd0;
                    stall_d = 16'd0;
                end
            end
            default: begin
                if (accept) begin
                    stall_d = 16'd0;
                    idx_d   = idx_q + 4'd1;
                    if (state_q == HDR && idx_q == LAST_HDR_IDX) begin
                        state_d = PAYLOAD;
                    end else if (state_q == PAYLOAD && idx_q == LAST_PAYLOAD_IDX) begin
                        state_d = CHK;
                    end else if (state_q == CHK) begin
                        state_d  = IDLE;
                        idx_d    = 4'd0;
                        rpt_done = 1'b1;
                        seq_d    = seq_q + 8'd1;
                    end
                end else if (stall_q == STALL_LIMIT) begin
                    // Abort leaves seq alone so the retried frame reuses it.
                    state_d     = IDLE;
                    idx_d       = 4'd0;
                    stall_d     = 16'd0;
                    rpt_timeout = 1'b1;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            seq_q   <= 8'h00;
            stall_q <= 16'd0;
            snap_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            stall_q <= stall_d;
            drop_q  <= rpt_req & (state_q != IDLE);
            if (capture) begin
                snap_q <= {error_count, min_latency, max_latency, average_latency, throughput};
            end
        end
    end

    rpt_check_accum u_check (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture),
        .update  (chk_update),
        .data_in (tx_byte),
        .result  (chk_byte)
    );

endmodule

// File: tb/tb_result_reporter_tx.sv
// Directed and randomized frame tests for result_reporter_tx against a frame-level model.
module tb_result_reporter_tx;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rpt_req;
    logic [15:0] error_count, min_latency, max_latency, average_latency;
    logic [31:0] throughput;
    logic        rpt_busy, rpt_done, rpt_timeout, rpt_drop;

    result_reporter_tx_if pc ();

    result_reporter_tx #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rpt_req         (rpt_req),
        .error_count     (error_count),
        .min_latency     (min_latency),
        .max_latency     (max_latency),
        .average_latency (average_latency),
        .throughput      (throughput),
        .pc_rsp          (pc),
        .rpt_busy        (rpt_busy),
        .rpt_done        (rpt_done),
        .rpt_timeout     (rpt_timeout),
        .rpt_drop        (rpt_drop)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_seq  = 8'h00;
    logic [7:0] got_b [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(pc.pc_rsp_valid), 32'd0);
        check({tag, "_data"}, 32'(pc.pc_rsp_data), 32'd0);
        check({tag, "_busy"}, 32'(rpt_busy), 32'd0);
        check({tag, "_done"}, 32'(rpt_done), 32'd0);
        check({tag, "_tmo"}, 32'(rpt_timeout), 32'd0);
        check({tag, "_drop"}, 32'(rpt_drop), 32'd0);
    endtask

    // Frame model: header, big-endian snapshot, then the check byte over B1..B14.
    task automatic build_frame(input logic [15:0] ec, mn, mx, av, input logic [31:0] tp,
                               output logic [7:0] fb [16]);
        logic [95:0] pl;
        int          sum;
        logic [7:0]  crc;
        pl    = {ec, mn, mx, av, tp};
        fb[0] = 8'hA5;
        fb[1] = exp_seq;
        fb[2] = 8'h0C;
        for (int i = 0; i < 12; i++) fb[3 + i] = pl[95 - 8 * i -: 8];
        sum = 0;
        crc = 8'h00;
        for (int i = 1; i < 15; i++) begin
            sum += int'(fb[i]);
            for (int b = 7; b >= 0; b--) begin
                logic fbk;
                fbk = crc[7] ^ fb[i][b];
                crc = crc << 1;
                if (fbk) crc = crc ^ 8'h07;
            end
        end
`ifdef RESULT_REPORTER_CRC8_EN
        fb[15] = crc;
`else
        fb[15] = 8'((256 - (sum % 256)) % 256);
`endif
    endtask

    // mode 0: ready=1, 1: ready toggles 1/0, 2: random ready, 3: ready drops after B4.
    task automatic run_frame(input logic [15:0] ec, mn, mx, av, input logic [31:0] tp,
                             input int mode, input int rst_at, input bit inj, input int tail);
        logic [7:0] exp_b [16];
        int         t, nacc, stall_run, ndone, ntmo, ndrop, done_t, bad_stable, bad_busy;
        bit         finished, prev_stall, rdy;
        logic [7:0] prev_data;
        build_frame(ec, mn, mx, av, tp, exp_b);
        @(negedge clk);
        pc.pc_rsp_ready = 1'b0;
        rpt_req         = 1'b1;
        error_count     = ec;
        min_latency     = mn;
        max_latency     = mx;
        average_latency = av;
        throughput      = tp;
        @(negedge clk);
        error_count     = 16'($urandom);
        min_latency     = 16'($urandom);
        max_latency     = 16'($urandom);
        average_latency = 16'($urandom);
        throughput      = $urandom;
        t = 0; nacc = 0; stall_run = 0; ndone = 0; ntmo = 0; ndrop = 0; done_t = -1;
        bad_stable = 0; bad_busy = 0; finished = 0; prev_stall = 0; prev_data = 8'h00;
        while (!finished && t < 200) begin
            if (nacc == rst_at) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("rst_async");
                @(posedge clk);
                #1;
                check_idle_outputs("rst_edge");
                @(negedge clk);
                rst     = 1'b0;
                rpt_req = 1'b0;
                exp_seq = 8'h00;
                return;
            end
            rpt_req = inj && (t == 5 || t == 15);
            case (mode)
                1:       rdy = (t % 2 == 0);
                2:       rdy = (stall_run >= 3) || ($urandom_range(0, 3) != 0);
                3:       rdy = (nacc < 5);
                default: rdy = 1'b1;
            endcase
            pc.pc_rsp_ready = rdy;
            #1;
            if (t == 0) check("first_valid", 32'(pc.pc_rsp_valid), 32'd1);
            if (prev_stall && pc.pc_rsp_data !== prev_data) bad_stable++;
            if (rpt_busy !== 1'b1) bad_busy++;
            if (rpt_drop === 1'b1) ndrop++;
            if (pc.pc_rsp_valid === 1'b1 && rdy) begin
                if (nacc < 16) begin
                    check($sformatf("byte%0d", nacc), 32'(pc.pc_rsp_data), 32'(exp_b[nacc]));
                    got_b[nacc] = pc.pc_rsp_data;
                end
                nacc++;
                stall_run = 0;
            end else begin
                stall_run++;
            end
            prev_stall = (pc.pc_rsp_valid === 1'b1) && !rdy;
            prev_data  = pc.pc_rsp_data;
            if (rpt_done === 1'b1) begin
                ndone++;
                done_t   = t;
                finished = 1;
                check("done_on_last_byte", 32'(nacc), 32'd16);
            end
            if (rpt_timeout === 1'b1) begin
                ntmo++;
                finished = 1;
            end
            t++;
            if (!finished) @(negedge clk);
        end
        check("frame_ended", 32'(finished), 32'd1);
        check("stable_in_stall", 32'(bad_stable), 32'd0);
        check("busy_in_frame", 32'(bad_busy), 32'd0);
        if (mode == 3) begin
            check("tmo_pulses", 32'(ntmo), 32'd1);
            check("tmo_no_done", 32'(ndone), 32'd0);
            check("tmo_bytes", 32'(nacc), 32'd5);
            check("tmo_stall_cycles", 32'(stall_run), 32'(TMO));
        end else begin
            check("done_pulses", 32'(ndone), 32'd1);
            check("no_tmo", 32'(ntmo), 32'd0);
            exp_seq = exp_seq + 8'd1;
            if (mode == 0) check("clocks_to_done", 32'(done_t + 1), 32'd16);
            if (mode == 1) check("clocks_to_done", 32'(done_t + 1), 32'd31);
        end
        for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            rpt_req = 1'b0;
            #1;
            if (rpt_drop === 1'b1) ndrop++;
            check("tail_valid", 32'(pc.pc_rsp_valid), 32'd0);
            check("tail_busy", 32'(rpt_busy), 32'd0);
            check("tail_done", 32'(rpt_done), 32'd0);
            check("tail_tmo", 32'(rpt_timeout), 32'd0);
        end
        if (tail > 0) check("drop_pulses", 32'(ndrop), inj ? 32'd2 : 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        rpt_req         = 1'b0;
        pc.pc_rsp_ready = 1'b0;
        error_count     = '0;
        min_latency     = '0;
        max_latency     = '0;
        average_latency = '0;
        throughput      = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Known frame: A5 00 0C 00 03 00*10 F1, then seq advances to 01.
        run_frame(16'h0003, 16'h0, 16'h0, 16'h0, 32'h0, 0, -1, 1'b0, 2);
`ifndef RESULT_REPORTER_CRC8_EN
        check("known_chk", 32'(got_b[15]), 32'h0000_00F1);
`endif
        check("known_b4", 32'(got_b[4]), 32'h0000_0003);
        run_frame(16'h0003, 16'h0, 16'h0, 16'h0, 32'h0, 1, -1, 1'b0, 1);

        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                  3, -1, 1'b0, 2);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                  0, -1, 1'b0, 1);

        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                  0, -1, 1'b1, 3);

        for (int i = 0; i < 6; i++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                      2, -1, 1'b0, 1);
        end

        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                  0, 7, 1'b0, 0);

        // Sequence wrap: 257 back-to-back frames from seq 00.
        for (int i = 0; i < 257; i++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
                      0, -1, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
